// File: rtl/mem_port_arbiter.sv
// Arbitrates IF and DM ports onto one memory; DM has priority, IF is forced after STARVE_MAX lost contests. Optional MEM_ARB_TIMEOUT_EN.
// Latency is 2+L cycles from grant to ack, with at least one IDLE cycle between grants. stall_o is high while either port waits.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ack_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              stall_o,
    output logic              err_o
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BUSY_IF = 2'd1;
    localparam logic [1:0] S_BUSY_DM = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [3:0]        STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [DATA_W-1:0] TMO_DATA   = {(DATA_W/32){32'hDEAD_BEEF}};

    if (STARVE_MAX < 1 || STARVE_MAX > 15 || TIMEOUT < 1) begin : g_param_err
        $error("mem_port_arbiter: STARVE_MAX must be 1..15 and TIMEOUT at least 1");
    end

    logic [1:0]        state_q, state_d;
    logic              sel_dm_q, sel_dm_d;
    logic [3:0]        starve_q, starve_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              busy;
    logic              tmo_hit;
    logic              grant_if;

    assign busy = (state_q == S_BUSY_IF) || (state_q == S_BUSY_DM);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int              TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;

    // Counter is zero in IDLE/DONE, so every access starts from a clean count.
    assign tmo_hit = busy && (tmo_q == TMO_LAST);
    assign tmo_d   = busy ? tmo_q + 1'b1 : '0;
    assign err_d   = tmo_hit && !mem_ack_i;
    assign err_o   = err_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign err_o   = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        sel_dm_d    = sel_dm_q;
        starve_d    = starve_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        grant_if    = if_req_i && (!dm_req_i || starve_q == STARVE_LIM);
        case (state_q)
            S_IDLE: begin
                if (grant_if) begin
                    state_d     = S_BUSY_IF;
                    sel_dm_d    = 1'b0;
                    starve_d    = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr_i;
                    mem_wdata_d = '0;
                end else if (dm_req_i) begin
                    state_d     = S_BUSY_DM;
                    sel_dm_d    = 1'b1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we_i;
                    mem_addr_d  = dm_addr_i;
                    mem_wdata_d = dm_wdata_i;
                    if (if_req_i && starve_q != STARVE_LIM) begin
                        starve_d = starve_q + 4'd1;
                    end
                end
            end
            S_BUSY_IF, S_BUSY_DM: begin
                // A real ack in the final counted cycle still wins over the timeout.
                if (mem_ack_i) begin
                    state_d   = S_DONE;
                    mem_req_d = 1'b0;
                    if (sel_dm_q) dm_rdata_d = mem_rdata_i;
                    else          if_rdata_d = mem_rdata_i;
                end else if (tmo_hit) begin
                    state_d   = S_DONE;
                    mem_req_d = 1'b0;
                    if (sel_dm_q) dm_rdata_d = TMO_DATA;
                    else          if_rdata_d = TMO_DATA;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            sel_dm_q    <= 1'b0;
            starve_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            sel_dm_q    <= sel_dm_d;
            starve_q    <= starve_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign if_ack_o    = (state_q == S_DONE) && !sel_dm_q;
    assign dm_ack_o    = (state_q == S_DONE) && sel_dm_q;
    assign if_rdata_o  = if_rdata_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign stall_o     = (if_req_i && !if_ack_o) || (dm_req_i && !dm_ack_o);

endmodule
